prog_frame_loader: RTL and testbench

PROG_FRAME_LOADER -- requirements
Module: prog_frame_loader

---
 rtl/prog_frame_loader.sv | 186 ++++++++++++++++++
 tb/tb_prog_frame_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_frame_loader.sv
// rtl/prog_frame_loader.sv - UART frame parser feeding a timed external-memory write engine
// Frames: A5, ADR0..2, LEN0..1, N data bytes, CSUM; one-byte holding register between parser and engine.
module prog_frame_loader #(
  parameter int WR_CYCLES = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [20:0] adr,
  output logic [7:0]  data,
  output logic        write,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {
    P_IDLE, P_ADR0, P_ADR1, P_ADR2, P_LEN0, P_LEN1, P_DATA, P_CSUM
  } pstate_t;

  typedef enum logic [1:0] {
    E_IDLE, E_SETUP, E_PULSE, E_HOLD
  } estate_t;

  localparam logic [7:0]  SYNC        = 8'hA5;
  localparam logic [1:0]  ERR_NONE    = 2'd0;
  localparam logic [1:0]  ERR_CSUM    = 2'd1;
  localparam logic [1:0]  ERR_OVERRUN = 2'd2;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd3;
  localparam logic [3:0]  WR_LAST     = 4'(WR_CYCLES - 1);
  localparam logic [19:0] TO_LAST     = 20'(TIMEOUT - 1);

  pstate_t     p_state, p_next;
  estate_t     e_state, e_next;

  logic [7:0]  sum, sum_next;
  logic [7:0]  adr_lo, adr_mid, len_lo, hold_data;
  logic [15:0] len, data_cnt;
  logic [19:0] idle_cnt;
  logic [3:0]  pulse_cnt;
  logic        hold_full, csum_seen;
  logic        rx_take, accept, consume, eng_free, timed_out;
  logic        err_set, done_set;
  logic [1:0]  err_code;

  assign sum_next  = sum + rx_data;
  // Once a good CSUM is seen, further bytes are ignored until done is issued.
  assign rx_take   = rx_valid && !csum_seen;
  assign accept    = rx_take && (p_state == P_DATA) && !hold_full;
  assign eng_free  = (e_state == E_IDLE) && !hold_full;
  assign timed_out = (p_state != P_IDLE) && !csum_seen && !rx_valid && (idle_cnt == TO_LAST);
  assign consume   = hold_full && (e_next == E_SETUP);

  assign write = (e_state == E_PULSE);
  assign busy  = (p_state != P_IDLE) || (e_state != E_IDLE) || hold_full;

  always_comb begin
    p_next   = p_state;
    err_set  = 1'b0;
    err_code = ERR_NONE;
    done_set = 1'b0;
    if (timed_out) begin
      p_next   = P_IDLE;
      err_set  = 1'b1;
      err_code = ERR_TIMEOUT;
    end else if (csum_seen) begin
      if (eng_free) begin
        p_next   = P_IDLE;
        done_set = 1'b1;
      end
    end else if (rx_valid) begin
      case (p_state)
        P_IDLE: if (rx_data == SYNC) p_next = P_ADR0;
        P_ADR0: p_next = P_ADR1;
        P_ADR1: p_next = P_ADR2;
        P_ADR2: p_next = P_LEN0;
        P_LEN0: p_next = P_LEN1;
        P_LEN1: p_next = ({rx_data, len_lo} == 16'd0) ? P_CSUM : P_DATA;
        P_DATA: begin
          if (hold_full) begin
            p_next   = P_IDLE;
            err_set  = 1'b1;
            err_code = ERR_OVERRUN;
          end else if (data_cnt + 16'd1 == len) begin
            p_next = P_CSUM;
          end
        end
        P_CSUM: begin
          if (sum_next != 8'h00) begin
            p_next   = P_IDLE;
            err_set  = 1'b1;
            err_code = ERR_CSUM;
          end
        end
        default: p_next = P_IDLE;
      endcase
    end
  end

  always_comb begin
    e_next = e_state;
    case (e_state)
      E_IDLE:  if (hold_full) e_next = E_SETUP;
      E_SETUP: e_next = E_PULSE;
      E_PULSE: if (pulse_cnt == WR_LAST) e_next = E_HOLD;
      E_HOLD:  e_next = hold_full ? E_SETUP : E_IDLE;
      default: e_next = E_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      p_state   <= P_IDLE;
      e_state   <= E_IDLE;
      adr       <= '0;
      data      <= '0;
      done      <= 1'b0;
      err       <= ERR_NONE;
      sum       <= '0;
      idle_cnt  <= '0;
      adr_lo    <= '0;
      adr_mid   <= '0;
      len_lo    <= '0;
      len       <= '0;
      data_cnt  <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      csum_seen <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      p_state <= p_next;
      e_state <= e_next;
      done    <= done_set;

      if (rx_valid || (p_state == P_IDLE) || csum_seen || timed_out)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 20'd1;

      if (rx_take && (p_state == P_IDLE) && (rx_data == SYNC))
        err <= ERR_NONE;
      else if (err_set && (err == ERR_NONE))
        err <= err_code;

      if (p_next == P_IDLE)
        csum_seen <= 1'b0;
      else if (rx_take && (p_state == P_CSUM))
        csum_seen <= 1'b1;

      if (e_state == E_PULSE)
        pulse_cnt <= pulse_cnt + 4'd1;
      else
        pulse_cnt <= '0;

      if (consume) begin
        data      <= hold_data;
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold_data <= rx_data;
        hold_full <= 1'b1;
        data_cnt  <= data_cnt + 16'd1;
      end

      if (e_state == E_HOLD)
        adr <= adr + 21'd1;

      if (rx_take) begin
        case (p_state)
          P_IDLE: if (rx_data == SYNC) sum <= '0;
          P_ADR0: begin adr_lo <= rx_data; sum <= sum_next; end
          P_ADR1: begin adr_mid <= rx_data; sum <= sum_next; end
          P_ADR2: begin adr <= {rx_data[4:0], adr_mid, adr_lo}; sum <= sum_next; end
          P_LEN0: begin len_lo <= rx_data; sum <= sum_next; end
          P_LEN1: begin len <= {rx_data, len_lo}; data_cnt <= '0; sum <= sum_next; end
          P_DATA: sum <= sum_next;
          P_CSUM: sum <= sum_next;
          default: sum <= sum;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_frame_loader.sv
// tb/tb_prog_frame_loader.sv - randomized scoreboard bench for prog_frame_loader
// Frame-level reference model predicts writes, done and err; a negedge monitor checks the memory bus.
module tb_prog_frame_loader;

  logic        clk;
  logic        n_reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [20:0] adr;
  logic [7:0]  data;
  logic        write;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  prog_frame_loader #(.WR_CYCLES(4), .TIMEOUT(100)) dut (
    .clk(clk), .n_reset(n_reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .adr(adr), .data(data), .write(write), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [20:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  int         exp_done_q[$];
  logic [7:0] payload[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  function automatic logic [7:0] noise();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h3C;
    return b;
  endfunction

  // Reference model: writes land at raw[20:0]+i mod 2^21; frame is good iff ADR0..CSUM sums to 0 mod 256.
  task automatic send_frame(input logic [23:0] raw, input int csum_ovr,
                            input int gmin, input int gmax, output int exp_err);
    logic [7:0]  hdr [5];
    logic [15:0] n;
    logic [7:0]  s, csum, tot;
    n = 16'(payload.size());
    hdr[0] = raw[7:0];
    hdr[1] = raw[15:8];
    hdr[2] = raw[23:16];
    hdr[3] = n[7:0];
    hdr[4] = n[15:8];
    s = 8'h00;
    foreach (payload[i]) begin
      wr_t w;
      w.a = raw[20:0] + 21'(i);
      w.d = payload[i];
      exp_q.push_back(w);
    end
    send_byte(8'hA5, $urandom_range(0, 3));
    for (int i = 0; i < 5; i++) begin
      s = s + hdr[i];
      send_byte(hdr[i], $urandom_range(0, 3));
    end
    foreach (payload[i]) begin
      s = s + payload[i];
      send_byte(payload[i], $urandom_range(gmin, gmax));
    end
    csum = (csum_ovr >= 0) ? 8'(csum_ovr) : 8'h00 - s;
    tot  = s + csum;
    exp_err = (tot == 8'h00) ? 0 : 1;
    if (tot == 8'h00) exp_done_q.push_back(1);
    send_byte(csum, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check({tag, "_idle_in_time"}, int'(n < 3000), 1);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_dones_left"}, exp_done_q.size(), 0);
  endtask

  // Bus monitor: every write rise pops the scoreboard; width and stability checked around the pulse.
  initial begin
    logic        wr_prev, wr_moved;
    logic [20:0] prev_adr, wr_adr;
    logic [7:0]  prev_data, wr_dat;
    int          wr_len;
    logic        done_prev;
    wr_t         ew;
    wr_prev = 1'b0; wr_moved = 1'b0; done_prev = 1'b0; wr_len = 0;
    prev_adr = '0; prev_data = '0; wr_adr = '0; wr_dat = '0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        wr_prev   = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (write && !wr_prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: adr=%0h data=%0h", adr, data);
          end else begin
            ew = exp_q.pop_front();
            check("wr_adr", int'(adr), int'(ew.a));
            check("wr_data", int'(data), int'(ew.d));
          end
          check("wr_setup_stable", int'(adr == prev_adr && data == prev_data), 1);
          wr_len = 1; wr_adr = adr; wr_dat = data; wr_moved = 1'b0;
        end else if (write) begin
          wr_len++;
          if (adr != wr_adr || data != wr_dat) wr_moved = 1'b1;
        end else if (wr_prev) begin
          check("wr_width", wr_len, 4);
          check("wr_hold_stable", int'(!wr_moved && adr == wr_adr && data == wr_dat), 1);
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: err=%0d", err);
          end else begin
            void'(exp_done_q.pop_front());
            check("done_after_writes", exp_q.size() + int'(write), 0);
          end
          check("done_one_cycle", int'(done_prev), 0);
        end
        wr_prev   = write;
        done_prev = done;
      end
      prev_adr  = adr;
      prev_data = data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          eerr, n;
    logic [23:0] raw;
    n_reset  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check("rst_adr", int'(adr), 0);
    check("rst_data", int'(data), 0);
    check("rst_write", int'(write), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    n_reset = 1'b1;
    tick();

    // Directed good frame, then the same frame with a wrong checksum.
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(24'h001000, -1, 5, 10, eerr);
    wait_idle("good");
    check("good_err", int'(err), 0);
    check("good_model_err", eerr, 0);

    send_frame(24'h001000, 8'h70, 5, 10, eerr);
    wait_idle("badcsum");
    check("badcsum_err", int'(err), 1);

    // Address wrap with ignored upper address bits set.
    payload = '{8'hAA, 8'hBB};
    send_frame(24'hFFFFFF, -1, 6, 6, eerr);
    wait_idle("wrap");
    check("wrap_err", int'(err), 0);

    // Overrun: data bytes on consecutive cycles.
    begin
      wr_t w;
      w.a = 21'h000200; w.d = 8'h77;
      exp_q.push_back(w);
    end
    send_byte(8'hA5, 1); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h03, 0); send_byte(8'h00, 2);
    send_byte(8'h77, 0); send_byte(8'h88, 3);
    send_byte(8'h99, 3); send_byte(8'h12, 0);
    wait_idle("overrun");
    check("overrun_err", int'(err), 2);

    // Timeout after LEN0.
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h30, 0); send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    repeat (95) tick();
    check("to_early_err", int'(err), 0);
    check("to_early_busy", int'(busy), 1);
    repeat (7) tick();
    check("to_err", int'(err), 3);
    check("to_busy", int'(busy), 0);

    // Reset in the middle of a write pulse; a sync byte during reset must be ignored.
    begin
      wr_t w;
      w.a = 21'h0ABCDE; w.d = 8'h5C;
      exp_q.push_back(w);
    end
    send_byte(8'hA5, 0); send_byte(8'hDE, 0); send_byte(8'hBC, 0); send_byte(8'h0A, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h5C, 0);
    n = 0;
    while (!write && n < 20) begin
      tick();
      n++;
    end
    check("mid_write_reached", int'(write), 1);
    tick();
    n_reset  = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick();
    check("midrst_write", int'(write), 0);
    check("midrst_adr", int'(adr), 0);
    check("midrst_data", int'(data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_popped", exp_q.size(), 0);
    n_reset  = 1'b1;
    rx_valid = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    tick();
    check("postrst_busy", int'(busy), 0);
    payload = '{8'hC1, 8'hC2};
    send_frame(24'h000040, -1, 5, 10, eerr);
    wait_idle("postrst");
    check("postrst_err", int'(err), 0);

    // Random frames with noise in IDLE, random lengths, some corrupted checksums.
    for (int f = 0; f < 16; f++) begin
      int nlen, ovr;
      payload.delete();
      nlen = $urandom_range(0, 5);
      for (int j = 0; j < nlen; j++) payload.push_back(8'($urandom));
      raw = 24'($urandom);
      if ($urandom_range(0, 3) == 0) raw[20:0] = 21'h1FFFFD;
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      repeat ($urandom_range(0, 3)) send_byte(noise(), $urandom_range(0, 2));
      send_frame(raw, ovr, 5, 10, eerr);
      wait_idle("rnd");
      check("rnd_err", int'(err), eerr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
